mdio_responder: RTL



---
 rtl/mdio_pkg.sv | 25 ++
 rtl/mdio_edge_sync.sv | 40 ++++
 rtl/mdio_responder.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_pkg.sv
// Shared definitions for the MDIO Clause 22 responder.
// Holds the frame FSM state encoding, the ST/OP field codes and the field lengths.
package mdio_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_RDATA,
        S_WDATA,
        S_SKIP
    } mdio_state_e;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] ST_BITS  = 2'b01;

    localparam int PHYAD_LEN = 5;
    localparam int REGAD_LEN = 5;
    localparam int DATA_LEN  = 16;

endpackage

// File: rtl/mdio_edge_sync.sv
// Brings the MDC/MDIO pad signals into the clk domain.
// Ports:
//   clk, aresetn   - system clock, async active-low reset
//   mdc, mdio_i    - raw pad inputs, asynchronous to clk
//   mdc_rise       - one-clk pulse per synchronized MDC rising edge
//   mdio_s         - synchronized MDIO value, aligned with mdc_rise
module mdio_edge_sync (
    input  logic clk,
    input  logic aresetn,
    input  logic mdc,
    input  logic mdio_i,
    output logic mdc_rise,
    output logic mdio_s
);

    // [0],[1] are the synchronizer; [2] is the previous synchronized value.
    logic [2:0] mdc_q, mdc_d;
    logic [1:0] mdio_q, mdio_d;

    always_comb begin
        mdc_d  = {mdc_q[1:0], mdc};
        mdio_d = {mdio_q[0], mdio_i};
    end

    // Reset to ones: an MDC that is already high at reset release is not
    // mistaken for a rising edge, and an idle (pulled-up) line reads as 1.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            mdc_q  <= 3'b111;
            mdio_q <= 2'b11;
        end else begin
            mdc_q  <= mdc_d;
            mdio_q <= mdio_d;
        end
    end

    assign mdc_rise = mdc_q[1] & ~mdc_q[2];
    assign mdio_s   = mdio_q[1];

endmodule

// File: rtl/mdio_responder.sv
// MDIO Clause 22 responder: decodes read/write frames for PHY_ADDR and
// exposes them on a simple register-access port.
// Ports:
//   clk, aresetn          - system clock (>= 8x MDC), async active-low reset
//   mdc, mdio_i           - management clock and MDIO pad input
//   mdio_o, mdio_t        - MDIO drive value and release (t=1 releases the line)
//   reg_addr              - register address of the current frame
//   reg_rd_en, reg_rdata  - read capture pulse and read data for reg_addr
//   reg_wr_en, reg_wdata  - one-clk write strobe and held write data
//   busy                  - high from ST detection until frame end or abort
//
// state   | meaning
// IDLE    | counting preamble ones; a 0 after saturation starts a frame
// ST      | second start bit, must be 1
// OP      | two opcode bits, read or write
// PHYAD   | five PHY address bits, MSB first
// REGAD   | five register address bits, reg_addr loads on the last one
// TA      | turnaround; addressed read starts driving after the first bit
// RDATA   | driving 16 read bits MSB first
// WDATA   | shifting in 16 write bits MSB first
// SKIP    | frame for another PHY, waiting out 16 data bits
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR     = 5'd1,
    parameter int         PREAMBLE_MIN = 32
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_t,
    output logic [4:0]  reg_addr,
    output logic        reg_rd_en,
    input  logic [15:0] reg_rdata,
    output logic        reg_wr_en,
    output logic [15:0] reg_wdata,
    output logic        busy
);

    localparam logic [5:0] PRE_SAT = 6'(PREAMBLE_MIN);

    logic mdc_rise;
    logic mdio_s;

    mdio_edge_sync u_sync (
        .clk      (clk),
        .aresetn  (aresetn),
        .mdc      (mdc),
        .mdio_i   (mdio_i),
        .mdc_rise (mdc_rise),
        .mdio_s   (mdio_s)
    );

    mdio_state_e state_q, state_d;
    logic [5:0]  pre_cnt_q, pre_cnt_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] shift_q, shift_d;
    logic        is_read_q, is_read_d;
    logic        match_q, match_d;
    logic [4:0]  reg_addr_q, reg_addr_d;
    logic [15:0] reg_wdata_q, reg_wdata_d;
    logic        rd_en_q, rd_en_d;
    logic        wr_en_q, wr_en_d;
    logic        mdio_o_q, mdio_o_d;
    logic        mdio_t_q, mdio_t_d;
    logic        busy_q, busy_d;

    logic        to_idle;
    logic [1:0]  op_bits;

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        is_read_d   = is_read_q;
        match_d     = match_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;
        mdio_o_d    = mdio_o_q;
        mdio_t_d    = mdio_t_q;
        busy_d      = busy_q;
        to_idle     = 1'b0;
        op_bits     = {shift_q[0], mdio_s};

        if (mdc_rise) begin
            case (state_q)
                S_IDLE: begin
                    if (mdio_s) begin
                        if (pre_cnt_q != PRE_SAT) begin
                            pre_cnt_d = pre_cnt_q + 6'd1;
                        end
                    end else begin
                        pre_cnt_d = '0;
                        if (pre_cnt_q == PRE_SAT) begin
                            state_d = S_ST;
                            busy_d  = 1'b1;
                        end
                    end
                end

                S_ST: begin
                    if (mdio_s == ST_BITS[0]) begin
                        state_d   = S_OP;
                        bit_cnt_d = '0;
                    end else begin
                        to_idle = 1'b1;
                    end
                end

                S_OP: begin
                    shift_d = {shift_q[14:0], mdio_s};
                    if (bit_cnt_q == 5'd0) begin
                        bit_cnt_d = 5'd1;
                    end else if (op_bits == OP_READ || op_bits == OP_WRITE) begin
                        is_read_d = (op_bits == OP_READ);
                        state_d   = S_PHYAD;
                        bit_cnt_d = '0;
                    end else begin
                        to_idle = 1'b1;
                    end
                end

                S_PHYAD: begin
                    shift_d = {shift_q[14:0], mdio_s};
                    if (bit_cnt_q == 5'(PHYAD_LEN - 1)) begin
                        match_d   = ({shift_q[3:0], mdio_s} == PHY_ADDR);
                        state_d   = S_REGAD;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end

                S_REGAD: begin
                    shift_d = {shift_q[14:0], mdio_s};
                    if (bit_cnt_q == 5'(REGAD_LEN - 1)) begin
                        // Mismatched frames still publish the address; no
                        // strobe follows, so downstream ignores it.
                        reg_addr_d = {shift_q[3:0], mdio_s};
                        state_d    = S_TA;
                        bit_cnt_d  = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end

                S_TA: begin
                    if (bit_cnt_q == 5'd0) begin
                        bit_cnt_d = 5'd1;
                        // Drive the TA zero so the master sees it on the next edge.
                        if (is_read_q && match_q) begin
                            shift_d  = reg_rdata;
                            rd_en_d  = 1'b1;
                            mdio_t_d = 1'b0;
                            mdio_o_d = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = '0;
                        if (!match_q) begin
                            state_d = S_SKIP;
                        end else if (is_read_q) begin
                            state_d  = S_RDATA;
                            mdio_o_d = shift_q[15];
                            shift_d  = {shift_q[14:0], 1'b0};
                        end else begin
                            state_d = S_WDATA;
                        end
                    end
                end

                S_RDATA: begin
                    // D15 went out on the TA edge; 15 more bits, then release
                    // on the edge where the master samples D0.
                    if (bit_cnt_q == 5'(DATA_LEN - 1)) begin
                        to_idle = 1'b1;
                    end else begin
                        mdio_o_d  = shift_q[15];
                        shift_d   = {shift_q[14:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end

                S_WDATA: begin
                    shift_d = {shift_q[14:0], mdio_s};
                    if (bit_cnt_q == 5'(DATA_LEN - 1)) begin
                        reg_wdata_d = {shift_q[14:0], mdio_s};
                        wr_en_d     = 1'b1;
                        to_idle     = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end

                S_SKIP: begin
                    if (bit_cnt_q == 5'(DATA_LEN - 1)) begin
                        to_idle = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end

                default: begin
                    to_idle = 1'b1;
                end
            endcase

            if (to_idle) begin
                state_d   = S_IDLE;
                pre_cnt_d = '0;
                bit_cnt_d = '0;
                mdio_t_d  = 1'b1;
                mdio_o_d  = 1'b1;
                busy_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            pre_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            is_read_q   <= 1'b0;
            match_q     <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            mdio_o_q    <= 1'b1;
            mdio_t_q    <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            is_read_q   <= is_read_d;
            match_q     <= match_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            mdio_o_q    <= mdio_o_d;
            mdio_t_q    <= mdio_t_d;
            busy_q      <= busy_d;
        end
    end

    assign mdio_o    = mdio_o_q;
    assign mdio_t    = mdio_t_q;
    assign reg_addr  = reg_addr_q;
    assign reg_rd_en = rd_en_q;
    assign reg_wr_en = wr_en_q;
    assign reg_wdata = reg_wdata_q;
    assign busy      = busy_q;

endmodule
